etapa_ex_muldiv: RTL and testbench

- Multi-cycle MULT/MULTU/DIV/DIVU unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched Registro1/Registro2 operands and the decoded funct, and owns the architectural HI/LO registers.
- Raises o_busy so the hazard unit stalls IF/ID/ID-EX while an operation is in flight.
- Also serves MTHI/MTLO writes and provides HI/LO to the MFHI/MFLO forwarding mux.

---
 rtl/etapa_ex_muldiv_pkg.sv | 27 ++
 rtl/etapa_ex_muldiv_sign_fix.sv | 17 +
 rtl/etapa_ex_muldiv.sv | 175 +++++++++++++++++
 tb/tb_etapa_ex_muldiv.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/etapa_ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation codes,
// FSM state encoding and the funct values the decoder maps onto them.
package etapa_ex_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/etapa_ex_muldiv_sign_fix.sv
// Conditional two's-complement negation. With negate=1 on a negative operand
// this yields its magnitude; with negate=1 on a magnitude it restores the sign.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // Pass the value through or return its two's-complement negation
  always_comb begin
    result = value;
    if (negate) result = ~value + W'(1);
  end

endmodule

// File: rtl/etapa_ex_muldiv.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operands are reduced to magnitudes on capture, iterated for NBITS cycles
// (shift-add or restoring shift-subtract), and the signs are applied in FIX.
module etapa_ex_muldiv
  import etapa_ex_muldiv_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int CNTBITS = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [NBITS-1:0] i_Registro1,
  input  logic [NBITS-1:0] i_Registro2,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  output logic             o_busy,
  output logic             o_done,
  output logic [NBITS-1:0] o_HI,
  output logic [NBITS-1:0] o_LO
);

  localparam logic [CNTBITS-1:0] LAST_ITER = CNTBITS'(NBITS - 1);

  state_t state, state_next;

  logic accept, iterate, finish, mt_write;

  logic is_signed_op, is_div_op;
  logic a_neg, b_neg;
  logic [NBITS-1:0] abs_a, abs_b;

  logic is_div_q, prod_neg_q, quot_neg_q, rem_neg_q;
  logic [NBITS-1:0] src_q, oth_q;
  logic [2*NBITS-1:0] acc_q, acc_next;
  logic [CNTBITS-1:0] cnt_q;

  logic [NBITS:0]   trial;
  logic [NBITS-1:0] diff;
  logic             q_bit;

  logic [2*NBITS-1:0] prod_fix;
  logic [NBITS-1:0]   quot_fix, rem_fix;

  logic [NBITS-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  assign is_signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign is_div_op    = (i_op == OP_DIV)  || (i_op == OP_DIVU);
  assign a_neg        = is_signed_op & i_Registro1[NBITS-1];
  assign b_neg        = is_signed_op & i_Registro2[NBITS-1];

  muldiv_sign_fix #(.W(NBITS)) u_abs_a (
    .value (i_Registro1),
    .negate(a_neg),
    .result(abs_a)
  );

  muldiv_sign_fix #(.W(NBITS)) u_abs_b (
    .value (i_Registro2),
    .negate(b_neg),
    .result(abs_b)
  );

  muldiv_sign_fix #(.W(2*NBITS)) u_prod (
    .value (acc_q),
    .negate(prod_neg_q),
    .result(prod_fix)
  );

  muldiv_sign_fix #(.W(NBITS)) u_quot (
    .value (acc_q[NBITS-1:0]),
    .negate(quot_neg_q),
    .result(quot_fix)
  );

  muldiv_sign_fix #(.W(NBITS)) u_rem (
    .value (acc_q[2*NBITS-1:NBITS]),
    .negate(rem_neg_q),
    .result(rem_fix)
  );

  // State register; reset returns to IDLE and aborts any operation
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for NBITS edges, one FIX edge
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (cnt_q == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept   = (state == IDLE) && i_start;
    iterate  = (state == RUN);
    finish   = (state == FIX);
    mt_write = (state == IDLE) && !i_start;
  end

  // One iteration step: multiply shifts the product left and adds the
  // multiplicand when the current multiplier bit (MSB first) is set; divide
  // brings down the next dividend bit and subtracts the divisor if it fits
  always_comb begin
    trial    = {acc_q[2*NBITS-1:NBITS], src_q[NBITS-1]};
    q_bit    = (trial >= {1'b0, oth_q});
    diff     = trial[NBITS-1:0] - oth_q;
    acc_next = {acc_q[2*NBITS-2:0], 1'b0}
             + ({{NBITS{1'b0}}, oth_q} & {(2*NBITS){src_q[NBITS-1]}});
    if (is_div_q)
      acc_next = {(q_bit ? diff : trial[NBITS-1:0]), acc_q[NBITS-2:0], q_bit};
  end

  // Datapath, HI/LO ownership and the registered busy/done flags.
  // A zero divisor keeps the quotient sign positive so LO stays all ones and
  // the remainder path restores the raw dividend into HI.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      is_div_q   <= 1'b0;
      prod_neg_q <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      src_q      <= '0;
      oth_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        is_div_q   <= is_div_op;
        prod_neg_q <= a_neg ^ b_neg;
        quot_neg_q <= (a_neg ^ b_neg) & (i_Registro2 != '0);
        rem_neg_q  <= a_neg;
        src_q      <= is_div_op ? abs_a : abs_b;
        oth_q      <= is_div_op ? abs_b : abs_a;
        acc_q      <= '0;
        cnt_q      <= '0;
        busy_q     <= 1'b1;
      end
      if (iterate) begin
        acc_q <= acc_next;
        src_q <= {src_q[NBITS-2:0], 1'b0};
        cnt_q <= cnt_q + CNTBITS'(1);
      end
      if (finish) begin
        hi_q   <= is_div_q ? rem_fix  : prod_fix[2*NBITS-1:NBITS];
        lo_q   <= is_div_q ? quot_fix : prod_fix[NBITS-1:0];
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
      if (mt_write) begin
        if (i_mthi) hi_q <= i_Registro1;
        if (i_mtlo) lo_q <= i_Registro1;
      end
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_HI   = hi_q;
  assign o_LO   = lo_q;

endmodule

// File: tb/tb_etapa_ex_muldiv.sv
// Self-checking bench for etapa_ex_muldiv: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_etapa_ex_muldiv;
  import etapa_ex_muldiv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_Registro1 = '0;
  logic [31:0] i_Registro2 = '0;
  logic        i_mthi = 1'b0;
  logic        i_mtlo = 1'b0;
  logic        o_busy, o_done;
  logic [31:0] o_HI, o_LO;

  int checks = 0;
  int fails  = 0;

  etapa_ex_muldiv #(.NBITS(32), .CNTBITS(6)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_Registro1(i_Registro1),
    .i_Registro2(i_Registro2),
    .i_mthi     (i_mthi),
    .i_mtlo     (i_mtlo),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_HI       (o_HI),
    .o_LO       (o_LO)
  );

  // Free-running clock
  always #5 i_clk = ~i_clk;

  // Reference: full-width integer arithmetic with truncating division
  function automatic void model(input logic [1:0] op, input logic [31:0] a, b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    bit sgn;
    sgn = (op == OP_MULT) || (op == OP_DIV);
    sa  = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    sb  = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    if (op == OP_MULT || op == OP_MULTU) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Count busy cycles from the current negedge until o_done, optionally
  // injecting an ignored start plus MTHI in the middle of the operation
  task automatic wait_done(input bit disturb, output int nbusy, output bit seen);
    int c;
    nbusy = 0;
    seen  = 0;
    c     = 1;
    while (!seen && c <= 100) begin
      if (o_done) seen = 1;
      else begin
        if (o_busy) nbusy++;
        if (disturb && c == 5) begin
          i_start = 1'b1; i_op = OP_DIV;
          i_Registro1 = 32'h1234; i_Registro2 = 32'd7; i_mthi = 1'b1;
        end
        if (disturb && c == 6) begin
          i_start = 1'b0; i_mthi = 1'b0;
        end
        @(negedge i_clk);
        c++;
      end
    end
  endtask

  // Compare the done cycle against the model
  task automatic check_output(input string tag, input logic [1:0] op,
                              input logic [31:0] a, b, input int nbusy, input bit seen);
    logic [31:0] eh, el;
    model(op, a, b, eh, el);
    check({tag, " done"}, {31'b0, seen}, 32'd1);
    check({tag, " busy_cycles"}, nbusy, 32'd33);
    check({tag, " busy_in_done"}, {31'b0, o_busy}, 32'd0);
    check({tag, " HI"}, o_HI, eh);
    check({tag, " LO"}, o_LO, el);
  endtask

  // Issue one operation, wait for it and check result and pulse width
  task automatic apply_stimulus(input string tag, input logic [1:0] op,
                                input logic [31:0] a, b, input bit disturb);
    int  nbusy;
    bit  seen;
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_Registro1 = a; i_Registro2 = b;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done(disturb, nbusy, seen);
    check_output(tag, op, a, b, nbusy, seen);
    @(negedge i_clk);
    check({tag, " done_pulse"}, {31'b0, o_done}, 32'd0);
  endtask

  initial begin
    int          nbusy;
    bit          seen;
    logic [31:0] hold_hi, hold_lo, ra, rb;
    logic [1:0]  rop;

    // Reset state
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    check("reset busy", {31'b0, o_busy}, 32'd0);
    check("reset done", {31'b0, o_done}, 32'd0);
    check("reset HI", o_HI, 32'd0);
    check("reset LO", o_LO, 32'd0);

    // Directed corner cases
    apply_stimulus("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    apply_stimulus("mult_neg",  OP_MULT,  32'hFFFF_FFF9, 32'd3, 1'b0);
    apply_stimulus("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    apply_stimulus("divu_zero", OP_DIVU,  32'd100, 32'd0, 1'b0);
    apply_stimulus("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
    apply_stimulus("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    apply_stimulus("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);

    // Start and MTHI during busy are ignored; MTHI afterwards lands
    apply_stimulus("busy_ignore", OP_MULTU, 32'd5, 32'd6, 1'b1);
    i_mthi = 1'b1; i_Registro1 = 32'h1234;
    @(negedge i_clk);
    i_mthi = 1'b0;
    check("mthi HI", o_HI, 32'h0000_1234);
    check("mthi LO", o_LO, 32'd30);

    // Both MT strobes, then HI/LO hold with no activity
    i_mthi = 1'b1; i_mtlo = 1'b1; i_Registro1 = 32'hCAFE_0001;
    @(negedge i_clk);
    i_mthi = 1'b0; i_mtlo = 1'b0; i_Registro1 = 32'h0;
    repeat (5) @(negedge i_clk);
    check("mt_both HI", o_HI, 32'hCAFE_0001);
    check("mt_both LO", o_LO, 32'hCAFE_0001);

    // MTLO on the accept edge is ignored
    hold_lo = o_LO;
    i_start = 1'b1; i_mtlo = 1'b1; i_op = OP_MULTU;
    i_Registro1 = 32'd3; i_Registro2 = 32'd4;
    @(negedge i_clk);
    i_start = 1'b0; i_mtlo = 1'b0;
    check("mt_on_accept LO", o_LO, hold_lo);
    wait_done(1'b0, nbusy, seen);
    check_output("mt_on_accept", OP_MULTU, 32'd3, 32'd4, nbusy, seen);

    // Reset at cycle 10 of a DIVU aborts and clears HI/LO
    @(negedge i_clk);
    i_start = 1'b1; i_op = OP_DIVU; i_Registro1 = 32'd1000; i_Registro2 = 32'd7;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("abort busy", {31'b0, o_busy}, 32'd0);
    check("abort done", {31'b0, o_done}, 32'd0);
    check("abort HI", o_HI, 32'd0);
    check("abort LO", o_LO, 32'd0);
    seen = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (o_done) seen = 1;
    end
    check("abort no_done", {31'b0, seen}, 32'd0);
    apply_stimulus("after_abort", OP_DIVU, 32'd1000, 32'd7, 1'b0);

    // Back-to-back with i_start held through the done cycle
    @(negedge i_clk);
    i_start = 1'b1; i_op = OP_MULTU; i_Registro1 = 32'd9; i_Registro2 = 32'd11;
    @(negedge i_clk);
    i_op = OP_DIVU; i_Registro1 = 32'd1000; i_Registro2 = 32'd33;
    wait_done(1'b0, nbusy, seen);
    check_output("b2b_first", OP_MULTU, 32'd9, 32'd11, nbusy, seen);
    @(negedge i_clk);
    check("b2b reaccept busy", {31'b0, o_busy}, 32'd1);
    check("b2b reaccept done", {31'b0, o_done}, 32'd0);
    i_start = 1'b0;
    wait_done(1'b0, nbusy, seen);
    check_output("b2b_second", OP_DIVU, 32'd1000, 32'd33, nbusy, seen);

    // Random operations against the model
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 200); rb = $urandom_range(0, 20); end
        2: begin ra = $urandom; rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
        default: begin ra = $urandom; rb = (i % 3 == 0) ? 32'd0 : $urandom >> 16; end
      endcase
      apply_stimulus($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
    end

    // HI/LO hold indefinitely after the last operation
    hold_hi = o_HI;
    hold_lo = o_LO;
    repeat (20) @(negedge i_clk);
    check("final hold HI", o_HI, hold_hi);
    check("final hold LO", o_LO, hold_lo);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
